// File: rtl/fuzz_pkg.sv
// fuzz_pkg: shared state, record layout and width constants for the fuzz report collector.
// FUZZ_TIMESTAMP_EN widens each record with a 16-bit capture timestamp in the top bits.
package fuzz_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StCapture,
        StGap,
        StDone
    } fuzz_state_e;

    localparam int unsigned IP_W = 33;

    typedef struct packed {
        logic            timeout;
        logic            overflow;
        logic            mismatch;
        logic            hang;
        logic            crash;
        logic [IP_W-1:0] ip_output;
    } fuzz_rec_t;

    localparam int unsigned FLAG_CRASH    = 33;
    localparam int unsigned FLAG_HANG     = 34;
    localparam int unsigned FLAG_MISMATCH = 35;
    localparam int unsigned FLAG_OVERFLOW = 36;
    localparam int unsigned FLAG_TIMEOUT  = 37;

    localparam int unsigned BASE_REC_W = $bits(fuzz_rec_t);

`ifdef FUZZ_TIMESTAMP_EN
    localparam int unsigned TS_W  = 16;
    localparam int unsigned REC_W = BASE_REC_W + TS_W;
`else
    localparam int unsigned REC_W = BASE_REC_W;
`endif

    function automatic logic rec_flagged(input logic [BASE_REC_W-1:0] rec);
        return |rec[FLAG_TIMEOUT:FLAG_CRASH];
    endfunction

endpackage

// File: rtl/fuzz_record_fifo.sv
// fuzz_record_fifo: valid/ready record FIFO with wrap-bit pointers; push into a full FIFO
// succeeds only when a pop happens in the same cycle. Output reads zero while empty.
module fuzz_record_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_valid = !w_empty;
    assign o_full  = w_full;
    assign o_rdata = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/fuzz_report_collector.sv
// fuzz_report_collector: runs a fuzz campaign of run_count iterations and queues flagged results.
// Define FUZZ_TIMESTAMP_EN to append a free-running 16-bit capture timestamp to each record.
module fuzz_report_collector
    import fuzz_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      run_count,
    output logic             fuzz_enable,
    input  logic             fuzz_ack,
    input  logic             fuzz_crash,
    input  logic             fuzz_hang,
    input  logic             fuzz_mismatch,
    input  logic             fuzz_overflow,
    input  logic [32:0]      fuzz_ip_output,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [REC_W-1:0] rec_data,
    output logic             busy,
    output logic             done,
    output logic [15:0]      fail_count,
    output logic [7:0]       drop_count
);

    localparam int unsigned WD_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

    fuzz_state_e      r_state;
    logic [15:0]      r_run_count;
    logic [15:0]      r_iter;
    logic [WD_W-1:0]  r_wd;
    fuzz_rec_t        r_cap;
    logic             r_fuzz_enable;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_fail;
    logic [7:0]       r_drop;

    logic             w_pop;
    logic             w_full;
    logic             w_push_req;
    logic             w_drop;
    logic [15:0]      w_iter_next;
    logic [REC_W-1:0] w_rec_wdata;

    assign w_pop       = rec_valid && rec_ready;
    assign w_push_req  = (r_state == StCapture) && rec_flagged(r_cap);
    // A full FIFO still accepts the record when the host pops in the same cycle.
    assign w_drop      = w_push_req && w_full && !w_pop;
    assign w_iter_next = r_iter + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_run_count   <= '0;
            r_iter        <= '0;
            r_wd          <= '0;
            r_cap         <= '0;
            r_fuzz_enable <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fail        <= '0;
            r_drop        <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_run_count <= run_count;
                        r_iter      <= '0;
                        r_wd        <= '0;
                        if (run_count == 16'd0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= StRun;
                            r_fuzz_enable <= 1'b1;
                            r_busy        <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // Ack wins over a watchdog expiry landing in the same cycle.
                    if (fuzz_ack || (r_wd == WD_LAST)) begin
                        r_cap <= '{timeout:   !fuzz_ack,
                                   overflow:  fuzz_overflow,
                                   mismatch:  fuzz_mismatch,
                                   hang:      fuzz_hang,
                                   crash:     fuzz_crash,
                                   ip_output: fuzz_ip_output};
                        r_state       <= StCapture;
                        r_fuzz_enable <= 1'b0;
                        r_wd          <= '0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                StCapture: begin
                    if (w_push_req && (r_fail != 16'hFFFF)) r_fail <= r_fail + 16'd1;
                    if (w_drop && (r_drop != 8'hFF))        r_drop <= r_drop + 8'd1;
                    r_iter <= w_iter_next;
                    if (w_iter_next == r_run_count) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= StGap;
                    end
                end
                StGap: begin
                    r_state       <= StRun;
                    r_fuzz_enable <= 1'b1;
                end
                StDone: begin
                    if (!start) begin
                        r_state <= StIdle;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef FUZZ_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ts <= '0;
        else        r_ts <= r_ts + 16'd1;
    end

    assign w_rec_wdata = {r_ts, r_cap};
`else
    assign w_rec_wdata = r_cap;
`endif

    fuzz_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_req),
        .i_wdata (w_rec_wdata),
        .i_pop   (w_pop),
        .o_valid (rec_valid),
        .o_full  (w_full),
        .o_rdata (rec_data)
    );

    assign fuzz_enable = r_fuzz_enable;
    assign busy        = r_busy;
    assign done        = r_done;
    assign fail_count  = r_fail;
    assign drop_count  = r_drop;

endmodule

// File: doc/fuzz_report_collector.md
FUZZ_REPORT_COLLECTOR -- requirements
Module: fuzz_report_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning record FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning cycles in RUN without fuzz_ack before watchdog fires.
REQ-003 SHALL have ports as follows, one per line (name, direction, width, meaning):
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  level; begin campaign.
- run_count  in  16  fuzz iterations per campaign, sampled on start.
- fuzz_enable  out  1  enable to downstream-facing fuzzer stage.
- fuzz_ack  in  1  fuzzer iteration complete.
- fuzz_crash, fuzz_hang, fuzz_mismatch, fuzz_overflow  in  1 each  fuzzer status flags.
- fuzz_ip_output  in  33  fuzzer observed result.
- rec_valid  out  1  record available.
- rec_ready  in  1  host accepts record.
- rec_data  out  REC_W  record {timeout, overflow, mismatch, hang, crash, ip_output[32:0]} (+ timestamp, see REQ-022).
- busy  out  1  campaign active.
- done  out  1  campaign finished.
- fail_count  out  16  records generated (flagged iterations).
- drop_count  out  8  flagged iterations lost to full FIFO.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, CAPTURE, GAP, DONE.
REQ-005 IDLE: on start=1 SHALL latch run_count, clear iteration counter, go RUN; if latched run_count=0 SHALL go DONE directly.
REQ-006 RUN: fuzz_enable=1; watchdog counts from 0 each cycle; fuzz_ack=1 -> CAPTURE; watchdog == ACK_TIMEOUT-1 without ack -> CAPTURE with timeout flag set.
REQ-007 Ack and watchdog expiry in the same cycle SHALL be treated as ack (timeout flag 0).
REQ-008 CAPTURE: flags and fuzz_ip_output SHALL be sampled on the cycle fuzz_ack is seen (registered), fuzz_enable=0.
REQ-009 CAPTURE: if any of the 5 flags set, SHALL push one record; if FIFO full that cycle (after any same-cycle pop), SHALL drop it and increment drop_count.
REQ-010 CAPTURE: iteration counter +1; if equal to latched run_count -> DONE, else GAP.
REQ-011 GAP: exactly one cycle fuzz_enable=0, then RUN.
REQ-012 DONE: done=1, busy=0; stays until start=0, then IDLE.
REQ-013 busy=1 in RUN, CAPTURE, GAP.
REQ-014 FIFO: valid/ready handshake; pop when rec_valid & rec_ready; rec_data stable while rec_valid & !rec_ready; first-word latency 1 cycle after push.
REQ-015 Simultaneous push and pop when full SHALL both succeed; when empty, push only (no fall-through).
REQ-016 Pointers SHALL wrap modulo FIFO_DEPTH; full/empty via extra wrap bit.
REQ-017 fail_count increments per push attempt with flags (including dropped); fail_count and drop_count saturate at max.
REQ-018 start deasserted mid-campaign SHALL be ignored; campaign completes.
REQ-019 FIFO contents and counters SHALL persist across campaigns; cleared only by reset.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, fuzz_enable=0, rec_valid=0, busy=0, done=0, fail_count=0, drop_count=0, FIFO empty, iteration counter and watchdog 0; rec_data=0.
REQ-021 Reset asserted mid-campaign SHALL abort it; no record pushed for the in-flight iteration.

Configuration
REQ-022 With macro FUZZ_TIMESTAMP_EN defined, SHALL keep a free-running 16-bit cycle counter (wraps) and append its value at CAPTURE as rec_data[53:38]; REC_W=54. Without it, no counter, REC_W=38.

Structure
REQ-023 Package fuzz_pkg SHALL hold the FSM state enum, record struct typedef, flag bit index constants, REC_W.
REQ-024 FIFO SHALL be a separate sub-module fuzz_record_fifo (parameters DEPTH, WIDTH).

Verification
REQ-025 run_count=3, ack after 5 cycles each, all flags 0 -> three RUN/CAPTURE cycles, no records, done=1, fail_count=0.
REQ-026 run_count=1, ack with crash=1, ip_output=33'h0_DEAD_BEEF -> one record {00001, 0DEADBEEF}, fail_count=1.
REQ-027 run_count=1, no ack, ACK_TIMEOUT=10 -> CAPTURE 10 cycles after RUN entry, record timeout=1.
REQ-028 FIFO_DEPTH=4, rec_ready=0, 6 crash iterations -> 4 records held, drop_count=2, fail_count=6; then rec_ready=1 drains 4 in order.
REQ-029 Reset asserted during RUN of iteration 2 of 5 -> immediate IDLE, fuzz_enable=0, FIFO empty.
REQ-030 Build with FUZZ_TIMESTAMP_EN, two crash iterations -> timestamps strictly increasing by iteration spacing.
